// File: rtl/retro_catc_fetch_scheduler.sv
// Two-requester fetch arbiter in front of one external memory port. It drives the CATC
// Delay/FastCatchup inputs so that memory stalls pause the core and are caught up later.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no fetch outstanding; arbitrate and grant on any ReqValid
// ST_ISSUE | MemReqValid held with MemAddr stable until MemReqReady
// ST_WAIT  | request accepted; count cycles until data arrives or timeout
// ST_RESP  | one-cycle RespValid pulse to the granted requester
module retro_catc_fetch_scheduler #(
    parameter int AddrBits      = 24,
    parameter int DataBits      = 8,
    parameter int FastThreshold = 64,
    parameter int FastHold      = 4096,
    parameter int Timeout       = 65535
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [1:0]            ReqValid,
    input  logic [2*AddrBits-1:0] ReqAddr,
    output logic [1:0]            RespValid,
    output logic [DataBits-1:0]   RespData,
    output logic                  RespError,
    output logic                  MemReqValid,
    input  logic                  MemReqReady,
    output logic [AddrBits-1:0]   MemAddr,
    input  logic                  MemRespValid,
    input  logic [DataBits-1:0]   MemRespData,
    output logic                  Delay,
    output logic                  FastCatchup,
    output logic [1:0]            Grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] CNT_MAX     = 16'hFFFF;
    localparam logic [15:0] FAST_THRESH = 16'(FastThreshold);
    localparam logic [15:0] FAST_HOLD   = 16'(FastHold);
    localparam logic [15:0] TIMEOUT     = 16'(Timeout);

    state_t                state;
    state_t                state_nxt;
    logic                  rr;
    logic                  rr_nxt;
    logic [15:0]           wait_cnt;
    logic [15:0]           wait_cnt_nxt;
    logic [15:0]           wait_cnt_inc;
    logic [15:0]           hold_cnt;
    logic [15:0]           hold_cnt_nxt;
    logic [15:0]           hold_cnt_inc;
    logic                  winner;
    logic [1:0]            grant_nxt;
    logic [1:0]            resp_valid_nxt;
    logic [DataBits-1:0]   resp_data_nxt;
    logic                  resp_error_nxt;
    logic                  mem_req_valid_nxt;
    logic [AddrBits-1:0]   mem_addr_nxt;
    logic                  fast_nxt;

    assign wait_cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 16'd1;
    assign hold_cnt_inc = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + 16'd1;

    // The core must stall the very cycle a request shows up, so this cannot be registered.
    assign Delay = (|ReqValid) || (state != ST_IDLE);

    always_comb begin
        state_nxt         = state;
        rr_nxt            = rr;
        wait_cnt_nxt      = wait_cnt;
        hold_cnt_nxt      = '0;
        winner            = 1'b0;
        grant_nxt         = Grant;
        resp_valid_nxt    = 2'b00;
        resp_data_nxt     = '0;
        resp_error_nxt    = 1'b0;
        mem_req_valid_nxt = MemReqValid;
        mem_addr_nxt      = MemAddr;
        fast_nxt          = FastCatchup;

        case (state)
            ST_IDLE: begin
                if (|ReqValid) begin
                    winner            = (ReqValid == 2'b11) ? rr : ReqValid[1];
                    grant_nxt         = winner ? 2'b10 : 2'b01;
                    mem_addr_nxt      = winner ? ReqAddr[2*AddrBits-1:AddrBits]
                                               : ReqAddr[AddrBits-1:0];
                    mem_req_valid_nxt = 1'b1;
                    rr_nxt            = ~winner;
                    state_nxt         = ST_ISSUE;
                end else begin
                    // Only a quiet idle period counts toward releasing fast catch-up.
                    hold_cnt_nxt = hold_cnt_inc;
                    if (hold_cnt_inc == FAST_HOLD) begin
                        fast_nxt = 1'b0;
                    end
                end
            end

            ST_ISSUE: begin
                if (MemReqReady) begin
                    mem_req_valid_nxt = 1'b0;
                    if (MemRespValid) begin
                        resp_valid_nxt = Grant;
                        resp_data_nxt  = MemRespData;
                        state_nxt      = ST_RESP;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt_inc;
                if (wait_cnt_inc == FAST_THRESH) begin
                    fast_nxt = 1'b1;
                end
                // Data arriving on the timeout cycle still counts as a good response.
                if (MemRespValid) begin
                    resp_valid_nxt = Grant;
                    resp_data_nxt  = MemRespData;
                    state_nxt      = ST_RESP;
                end else if (wait_cnt_inc == TIMEOUT) begin
                    resp_valid_nxt = Grant;
                    resp_error_nxt = 1'b1;
                    state_nxt      = ST_RESP;
                end
            end

            ST_RESP: begin
                grant_nxt    = 2'b00;
                wait_cnt_nxt = '0;
                state_nxt    = ST_IDLE;
            end

            default: begin
                grant_nxt         = 2'b00;
                mem_req_valid_nxt = 1'b0;
                wait_cnt_nxt      = '0;
                state_nxt         = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            rr          <= 1'b0;
            wait_cnt    <= '0;
            hold_cnt    <= '0;
            Grant       <= 2'b00;
            RespValid   <= 2'b00;
            RespData    <= '0;
            RespError   <= 1'b0;
            MemReqValid <= 1'b0;
            MemAddr     <= '0;
            FastCatchup <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr          <= rr_nxt;
            wait_cnt    <= wait_cnt_nxt;
            hold_cnt    <= hold_cnt_nxt;
            Grant       <= grant_nxt;
            RespValid   <= resp_valid_nxt;
            RespData    <= resp_data_nxt;
            RespError   <= resp_error_nxt;
            MemReqValid <= mem_req_valid_nxt;
            MemAddr     <= mem_addr_nxt;
            FastCatchup <= fast_nxt;
        end
    end

endmodule
